// File: rtl/skew_mem_ctrl_pkg.sv
// Shared types and sizing helpers for the skewed memory-array address controller.
package skew_mem_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Step counter must reach (2^addr_w - 1) + (lanes - 1) without wrapping.
   function automatic int unsigned cnt_w(input int unsigned addr_w, input int unsigned lanes);
      return $clog2((64'd1 << addr_w) + 64'(lanes));
   endfunction

endpackage

// File: rtl/skew_lane.sv
// One memory lane: decodes the shared step count into this lane's enable and address.
module skew_lane #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned CNT_W  = 9
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              step_vld,
   input  logic [CNT_W-1:0]  t,
   input  logic [CNT_W-1:0]  lane_idx,
   input  logic              skew,
   input  logic [ADDR_W-1:0] num_rows,
   input  logic [ADDR_W-1:0] base,
   input  logic              rev,
   output logic              en,
   output logic [ADDR_W-1:0] addr
);

   logic              en_q, en_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]  lag;
   logic [CNT_W-1:0]  rel;
   logic [ADDR_W-1:0] r;
   logic [ADDR_W-1:0] addr_calc;
   logic              hit;

   // Row offset is t minus the lane lag; the t >= lag test keeps the subtraction unsigned.
   always_comb begin
      lag       = skew ? lane_idx : '0;
      rel       = t - lag;
      hit       = (t >= lag) && (rel < CNT_W'(num_rows));
      r         = rel[ADDR_W-1:0];
      addr_calc = rev ? (base - r) : (base + r);
      en_d      = step_vld && hit;
      addr_d    = en_d ? addr_calc : addr_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         en_q   <= 1'b0;
         addr_q <= '0;
      end else begin
         en_q   <= en_d;
         addr_q <= addr_d;
      end
   end

   assign en   = en_q;
   assign addr = addr_q;

endmodule

// File: rtl/skew_mem_ctrl.sv
// Per-direction address controller for a WIDTH_HEIGHT-lane memory array, aligned or systolic skew.
// Define SKEW_MEM_CTRL_REVERSE_EN to add the `reverse` input for descending row addresses.
module skew_mem_ctrl
   import skew_mem_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH_HEIGHT = 16,
   parameter int unsigned ADDR_W       = 8
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           start,
   input  logic [ADDR_W-1:0]              base_addr,
   input  logic [ADDR_W-1:0]              num_rows,
   input  logic                           skew,
   input  logic                           stall,
`ifdef SKEW_MEM_CTRL_REVERSE_EN
   input  logic                           reverse,
`endif
   output logic                           busy,
   output logic                           done,
   output logic [WIDTH_HEIGHT-1:0]        en,
   output logic [WIDTH_HEIGHT*ADDR_W-1:0] addr
);

   localparam int unsigned CNT_W = cnt_w(ADDR_W, WIDTH_HEIGHT);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  t_q, t_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [ADDR_W-1:0] rows_q, rows_d;
   logic              skew_q, skew_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
`ifdef SKEW_MEM_CTRL_REVERSE_EN
   logic              rev_q, rev_d;
`endif

   logic              step_vld;
   logic [CNT_W-1:0]  step_t;
   logic [CNT_W-1:0]  t_last;
   logic [ADDR_W-1:0] lane_base;
   logic [ADDR_W-1:0] lane_rows;
   logic              lane_skew;
   logic              lane_rev;

   // Lanes see the incoming request on the accept edge so step 0 appears one cycle after start.
   always_comb begin
      state_d   = state_q;
      t_d       = t_q;
      base_d    = base_q;
      rows_d    = rows_q;
      skew_d    = skew_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      step_vld  = 1'b0;
      step_t    = t_q;
      lane_base = base_q;
      lane_rows = rows_q;
      lane_skew = skew_q;
      t_last    = CNT_W'(rows_q) - CNT_W'(1)
                + (skew_q ? CNT_W'(WIDTH_HEIGHT - 1) : CNT_W'(0));
`ifdef SKEW_MEM_CTRL_REVERSE_EN
      rev_d     = rev_q;
      lane_rev  = rev_q;
`else
      lane_rev  = 1'b0;
`endif

      case (state_q)
         IDLE: begin
            if (start) begin
               base_d    = base_addr;
               rows_d    = num_rows;
               skew_d    = skew;
               t_d       = '0;
               busy_d    = 1'b1;
               lane_base = base_addr;
               lane_rows = num_rows;
               lane_skew = skew;
               step_t    = '0;
`ifdef SKEW_MEM_CTRL_REVERSE_EN
               rev_d     = reverse;
               lane_rev  = reverse;
`endif
               if (num_rows == '0) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d  = RUN;
                  step_vld = 1'b1;
               end
            end
         end
         RUN: begin
            if (stall) begin
               step_vld = 1'b0;
            end else if (t_q == t_last) begin
               state_d = DONE;
               done_d  = 1'b1;
            end else begin
               t_d      = t_q + CNT_W'(1);
               step_t   = t_q + CNT_W'(1);
               step_vld = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         t_q     <= '0;
         base_q  <= '0;
         rows_q  <= '0;
         skew_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef SKEW_MEM_CTRL_REVERSE_EN
         rev_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         t_q     <= t_d;
         base_q  <= base_d;
         rows_q  <= rows_d;
         skew_q  <= skew_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef SKEW_MEM_CTRL_REVERSE_EN
         rev_q   <= rev_d;
`endif
      end
   end

   assign busy = busy_q;
   assign done = done_q;

   for (genvar i = 0; i < int'(WIDTH_HEIGHT); i++) begin : g_lane
      skew_lane #(
         .ADDR_W (ADDR_W),
         .CNT_W  (CNT_W)
      ) u_lane (
         .clk      (clk),
         .reset    (reset),
         .step_vld (step_vld),
         .t        (step_t),
         .lane_idx (CNT_W'(i)),
         .skew     (lane_skew),
         .num_rows (lane_rows),
         .base     (lane_base),
         .rev      (lane_rev),
         .en       (en[i]),
         .addr     (addr[i*ADDR_W +: ADDR_W])
      );
   end

endmodule

// File: tb/tb_skew_mem_ctrl.sv
// Directed self-checking bench for skew_mem_ctrl at 4 lanes x 8-bit addresses.
module tb_skew_mem_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [7:0]  base_addr;
   logic [7:0]  num_rows;
   logic        skew;
   logic        stall;
`ifdef SKEW_MEM_CTRL_REVERSE_EN
   logic        reverse;
`endif
   logic        busy;
   logic        done;
   logic [3:0]  en;
   logic [31:0] addr;

   int n_vec = 0;
   int n_err = 0;

   skew_mem_ctrl #(
      .WIDTH_HEIGHT (4),
      .ADDR_W       (8)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .base_addr (base_addr),
      .num_rows  (num_rows),
      .skew      (skew),
      .stall     (stall),
`ifdef SKEW_MEM_CTRL_REVERSE_EN
      .reverse   (reverse),
`endif
      .busy      (busy),
      .done      (done),
      .en        (en),
      .addr      (addr)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [7:0] b, input logic [7:0] n, input logic s);
      start     = 1'b1;
      base_addr = b;
      num_rows  = n;
      skew      = s;
      tick();
      start     = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
      n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
      n_vec++; if (en !== 4'h0) begin n_err++; $display("FAIL reset_en got %h want 0", en); end
      n_vec++; if (addr !== 32'h0) begin n_err++; $display("FAIL reset_addr got %h want 0", addr); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_aligned();
      logic [7:0] exp_a [3];
      exp_a[0] = 8'h10; exp_a[1] = 8'h11; exp_a[2] = 8'h12;
      issue(8'h10, 8'd3, 1'b0);
      for (int k = 0; k < 3; k++) begin
         n_vec++; if (en !== 4'hF) begin n_err++; $display("FAIL aligned_en step %0d got %h want f", k, en); end
         n_vec++; if (addr !== {4{exp_a[k]}}) begin n_err++; $display("FAIL aligned_addr step %0d got %h want %h", k, addr, {4{exp_a[k]}}); end
         n_vec++; if (busy !== 1'b1 || done !== 1'b0) begin n_err++; $display("FAIL aligned_busy step %0d got busy=%b done=%b want 1/0", k, busy, done); end
         tick();
      end
      n_vec++; if (done !== 1'b1 || en !== 4'h0) begin n_err++; $display("FAIL aligned_done got done=%b en=%h want 1/0", done, en); end
      tick();
      n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL aligned_idle got busy=%b done=%b want 0/0", busy, done); end
   endtask

   task automatic test_skewed();
      logic [3:0] exp_en [5];
      exp_en[0] = 4'h1; exp_en[1] = 4'h3; exp_en[2] = 4'h6; exp_en[3] = 4'hC; exp_en[4] = 4'h8;
      issue(8'h00, 8'd2, 1'b1);
      for (int k = 0; k < 5; k++) begin
         n_vec++; if (en !== exp_en[k]) begin n_err++; $display("FAIL skew_en step %0d got %h want %h", k, en, exp_en[k]); end
         for (int i = 0; i < 4; i++) begin
            if (exp_en[k][i]) begin
               n_vec++;
               if (addr[i*8 +: 8] !== 8'(k - i)) begin
                  n_err++; $display("FAIL skew_addr step %0d lane %0d got %h want %h", k, i, addr[i*8 +: 8], 8'(k - i));
               end
            end
         end
         if (k == 4) begin
            n_vec++; if (addr[7:0] !== 8'h01) begin n_err++; $display("FAIL skew_hold lane0 got %h want 01", addr[7:0]); end
         end
         tick();
      end
      n_vec++; if (done !== 1'b1 || en !== 4'h0) begin n_err++; $display("FAIL skew_done got done=%b en=%h want 1/0", done, en); end
      tick();
   endtask

   task automatic test_wrap();
      logic [7:0] exp_a [4];
      exp_a[0] = 8'hFE; exp_a[1] = 8'hFF; exp_a[2] = 8'h00; exp_a[3] = 8'h01;
      issue(8'hFE, 8'd4, 1'b0);
      for (int k = 0; k < 4; k++) begin
         n_vec++; if (en !== 4'hF || addr !== {4{exp_a[k]}}) begin n_err++; $display("FAIL wrap step %0d got en=%h addr=%h want f/%h", k, en, addr, {4{exp_a[k]}}); end
         tick();
      end
      n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL wrap_done got %b want 1", done); end
      tick();
   endtask

   task automatic test_stall();
      issue(8'h10, 8'd3, 1'b0);
      n_vec++; if (en !== 4'hF || addr !== {4{8'h10}}) begin n_err++; $display("FAIL stall_first got en=%h addr=%h want f/10101010", en, addr); end
      stall = 1'b1;
      for (int k = 0; k < 2; k++) begin
         tick();
         n_vec++; if (en !== 4'h0 || addr !== {4{8'h10}} || done !== 1'b0) begin n_err++; $display("FAIL stall_hold cyc %0d got en=%h addr=%h done=%b want 0/10101010/0", k, en, addr, done); end
      end
      stall = 1'b0;
      tick();
      n_vec++; if (en !== 4'hF || addr !== {4{8'h11}}) begin n_err++; $display("FAIL stall_resume got en=%h addr=%h want f/11111111", en, addr); end
      tick();
      n_vec++; if (en !== 4'hF || addr !== {4{8'h12}} || done !== 1'b0) begin n_err++; $display("FAIL stall_last got en=%h addr=%h done=%b want f/12121212/0", en, addr, done); end
      tick();
      n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL stall_done got %b want 1", done); end
      tick();
   endtask

   task automatic test_empty();
      issue(8'h33, 8'd0, 1'b1);
      n_vec++; if (done !== 1'b1 || en !== 4'h0 || busy !== 1'b1) begin n_err++; $display("FAIL empty_done got done=%b en=%h busy=%b want 1/0/1", done, en, busy); end
      tick();
      n_vec++; if (done !== 1'b0 || en !== 4'h0 || busy !== 1'b0) begin n_err++; $display("FAIL empty_idle got done=%b en=%h busy=%b want 0/0/0", done, en, busy); end
   endtask

   task automatic test_back_to_back();
      issue(8'h20, 8'd3, 1'b0);
      n_vec++; if (addr !== {4{8'h20}}) begin n_err++; $display("FAIL ign_step0 got %h want 20202020", addr); end
      start = 1'b1; base_addr = 8'h80; num_rows = 8'd1; skew = 1'b1;
      tick();
      n_vec++; if (en !== 4'hF || addr !== {4{8'h21}}) begin n_err++; $display("FAIL ign_step1 got en=%h addr=%h want f/21212121", en, addr); end
      tick();
      n_vec++; if (en !== 4'hF || addr !== {4{8'h22}}) begin n_err++; $display("FAIL ign_step2 got en=%h addr=%h want f/22222222", en, addr); end
      base_addr = 8'h40; skew = 1'b0;
      tick();
      n_vec++; if (done !== 1'b1 || en !== 4'h0) begin n_err++; $display("FAIL ign_done got done=%b en=%h want 1/0", done, en); end
      tick();
      n_vec++; if (busy !== 1'b0 || en !== 4'h0) begin n_err++; $display("FAIL b2b_idle got busy=%b en=%h want 0/0", busy, en); end
      tick();
      start = 1'b0;
      n_vec++; if (busy !== 1'b1 || en !== 4'hF || addr !== {4{8'h40}}) begin n_err++; $display("FAIL b2b_accept got busy=%b en=%h addr=%h want 1/f/40404040", busy, en, addr); end
      tick();
      n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL b2b_done got %b want 1", done); end
      tick();
   endtask

   task automatic test_reset_mid();
      issue(8'h00, 8'd2, 1'b1);
      tick();
      tick();
      n_vec++; if (en !== 4'h6) begin n_err++; $display("FAIL rmid_pre got en=%h want 6", en); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_vec++; if (en !== 4'h0 || addr !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL rmid_clear got en=%h addr=%h busy=%b done=%b want all 0", en, addr, busy, done); end
      for (int k = 0; k < 4; k++) begin
         tick();
         n_vec++; if (done !== 1'b0 || busy !== 1'b0 || en !== 4'h0) begin n_err++; $display("FAIL rmid_after cyc %0d got done=%b busy=%b en=%h want 0/0/0", k, done, busy, en); end
      end
   endtask

`ifdef SKEW_MEM_CTRL_REVERSE_EN
   task automatic test_reverse();
      logic [7:0] exp_a [3];
      exp_a[0] = 8'h01; exp_a[1] = 8'h00; exp_a[2] = 8'hFF;
      reverse = 1'b1;
      issue(8'h01, 8'd3, 1'b0);
      reverse = 1'b0;
      for (int k = 0; k < 3; k++) begin
         n_vec++; if (en !== 4'hF || addr !== {4{exp_a[k]}}) begin n_err++; $display("FAIL reverse step %0d got en=%h addr=%h want f/%h", k, en, addr, {4{exp_a[k]}}); end
         tick();
      end
      n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL reverse_done got %b want 1", done); end
      tick();
   endtask
`endif

   initial begin
      reset     = 1'b1;
      start     = 1'b0;
      base_addr = 8'h00;
      num_rows  = 8'h00;
      skew      = 1'b0;
      stall     = 1'b0;
`ifdef SKEW_MEM_CTRL_REVERSE_EN
      reverse   = 1'b0;
`endif
      test_reset();
      test_aligned();
      test_skewed();
      test_wrap();
      test_stall();
      test_empty();
      test_back_to_back();
      test_reset_mid();
`ifdef SKEW_MEM_CTRL_REVERSE_EN
      test_reverse();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
